// File: rtl/alu_core_if.sv
// Operand/result bundle for alu_core. Bit 0 of every field is the MSB.
interface alu_core_if;
  logic [0:63] rA_64bit_val;
  logic [0:63] rB_64bit_val;
  logic [0:5]  R_ins;
  logic [0:5]  Op_code;
  logic [0:1]  WW;
  logic [0:63] ALU_out;

  // Single-cycle streaming: no valid/ready. The master presents an operation
  // every cycle and the result for it appears on ALU_out one rising edge later.
  modport master (
    output rA_64bit_val, rB_64bit_val, R_ins, Op_code, WW,
    input  ALU_out
  );
  modport slave (
    input  rA_64bit_val, rB_64bit_val, R_ins, Op_code, WW,
    output ALU_out
  );
endinterface

// File: rtl/alu_core.sv
// SIMD ALU: lane-wise arithmetic on 8/16/32/64-bit lanes, one registered result per clock.
module alu_core (
  input  logic      clk,
  input  logic      rst_n,
  alu_core_if.slave bus
);

  typedef enum logic [4:0] {
    OP_NONE, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MOV,
    OP_ADD, OP_SUB, OP_MULEU, OP_MULOU, OP_SLL, OP_SRL, OP_SRA,
    OP_RTTH, OP_DIV, OP_MOD, OP_SQEU, OP_SQOU, OP_SQRT
  } op_e;

  op_e         op;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] res;
  logic [63:0] q;
  logic [63:0] lane_res [4];

  // Big-endian [0:63] ports map onto little-endian vectors, so a[63] is bit 0.
  assign a = bus.rA_64bit_val;
  assign b = bus.rB_64bit_val;

  always_comb begin
    op = OP_NONE;
    if (bus.Op_code == 6'b101010) begin
      case (bus.R_ins)
        6'd1:  op = OP_AND;
        6'd2:  op = OP_OR;
        6'd3:  op = OP_XOR;
        6'd4:  op = OP_NOT;
        6'd5:  op = OP_MOV;
        6'd6:  op = OP_ADD;
        6'd7:  op = OP_SUB;
        6'd8:  op = OP_MULEU;
        6'd9:  op = OP_MULOU;
        6'd10: op = OP_SLL;
        6'd11: op = OP_SRL;
        6'd12: op = OP_SRA;
        6'd13: op = OP_RTTH;
        6'd14: op = OP_DIV;
        6'd15: op = OP_MOD;
        6'd16: op = OP_SQEU;
        6'd17: op = OP_SQOU;
        6'd18: op = OP_SQRT;
        default: op = OP_NONE;
      endcase
    end
  end

  // One datapath per lane width; WW picks which one reaches the register.
  for (genvar g = 0; g < 4; g++) begin : g_width
    localparam int W  = 8 << g;
    localparam int N  = 64 / W;
    localparam int SW = $clog2(W);

    logic [63:0] lane_part;
    logic [63:0] mul_part;

    for (genvar k = 0; k < N; k++) begin : g_lane
      logic [W-1:0]  la;
      logic [W-1:0]  lb;
      logic [W-1:0]  r;
      logic [W-1:0]  sq_x;
      logic [W-1:0]  sq_r;
      logic [W-1:0]  sq_b;
      logic [W-1:0]  sq_t;
      logic [SW-1:0] sh;

      // Lane 0 is the most significant lane.
      assign la = a[63-k*W -: W];
      assign lb = b[63-k*W -: W];
      assign sh = lb[SW-1:0];

      // Digit-by-digit integer square root, two radicand bits per step.
      always_comb begin
        sq_x = la;
        sq_r = '0;
        sq_b = '0;
        sq_b[W-2] = 1'b1;
        sq_t = '0;
        for (int i = 0; i < W/2; i++) begin
          sq_t = sq_r + sq_b;
          if (sq_x >= sq_t) begin
            sq_x = sq_x - sq_t;
            sq_r = (sq_r >> 1) + sq_b;
          end else begin
            sq_r = sq_r >> 1;
          end
          sq_b = sq_b >> 2;
        end
      end

      always_comb begin
        case (op)
          OP_ADD:  r = la + lb;
          OP_SUB:  r = la - lb;
          OP_SLL:  r = la << sh;
          OP_SRL:  r = la >> sh;
          OP_SRA:  r = $signed(la) >>> sh;
          OP_RTTH: r = {la[W/2-1:0], la[W-1:W/2]};
          OP_DIV:  r = (lb == '0) ? '1 : la / lb;
          OP_MOD:  r = (lb == '0) ? la : la % lb;
          OP_SQRT: r = sq_r;
          default: r = '0;
        endcase
      end

      assign lane_part[63-k*W -: W] = r;
    end

    // Widening multiplies pair lanes into 2W fields; there is no 128-bit field.
    if (W < 64) begin : g_mul
      for (genvar p = 0; p < N/2; p++) begin : g_field
        logic [W-1:0]   ea;
        logic [W-1:0]   oa;
        logic [W-1:0]   eb;
        logic [W-1:0]   ob;
        logic [2*W-1:0] f;

        assign ea = a[63-2*p*W -: W];
        assign oa = a[63-2*p*W-W -: W];
        assign eb = b[63-2*p*W -: W];
        assign ob = b[63-2*p*W-W -: W];

        always_comb begin
          case (op)
            OP_MULEU: f = {{W{1'b0}}, ea} * {{W{1'b0}}, eb};
            OP_MULOU: f = {{W{1'b0}}, oa} * {{W{1'b0}}, ob};
            OP_SQEU:  f = {{W{1'b0}}, ea} * {{W{1'b0}}, ea};
            OP_SQOU:  f = {{W{1'b0}}, oa} * {{W{1'b0}}, oa};
            default:  f = '0;
          endcase
        end

        assign mul_part[63-2*p*W -: 2*W] = f;
      end
    end else begin : g_nomul
      assign mul_part = '0;
    end

    // Lane and multiply paths are each zero unless their op is selected.
    assign lane_res[g] = lane_part | mul_part;
  end

  always_comb begin
    case (op)
      OP_NONE: res = '0;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOT:  res = ~a;
      OP_MOV:  res = a;
      default: res = lane_res[bus.WW];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= res;
  end

  assign bus.ALU_out = q;

endmodule

// File: tb/tb_alu_core.sv
// Scoreboarded random test of alu_core against a lane-arithmetic reference model.
module tb_alu_core;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [63:0] exp_q[$];
  logic [5:0]  tag_q[$];

  alu_core_if bus ();

  alu_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every result appears one edge after it was issued.
  always @(posedge clk) begin
    logic [63:0] e;
    logic [5:0]  t;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check($sformatf("result rins=%0d", t), bus.ALU_out, e);
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] lane_of(input logic [63:0] v, input int k, input int w,
                                          input logic [63:0] mask);
    return (v >> (64 - (k + 1) * w)) & mask;
  endfunction

  function automatic logic [63:0] isqrt(input logic [63:0] v, input int w);
    logic [127:0] lo, hi, mid;
    lo = 0;
    hi = (128'd1 << (w / 2)) - 1;
    while (lo < hi) begin
      mid = (lo + hi + 1) >> 1;
      if (mid * mid <= {64'd0, v}) lo = mid;
      else hi = mid - 1;
    end
    return lo[63:0];
  endfunction

  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic [5:0] rins, input logic [5:0] opc,
                                        input logic [1:0] ww);
    int w, n, s;
    logic [63:0]  mask, res, la, lb, r, ea, oa, eb, ob;
    logic [127:0] prod;
    if (opc != 6'b101010) return 64'd0;
    case (rins)
      6'd1: return a & b;
      6'd2: return a | b;
      6'd3: return a ^ b;
      6'd4: return ~a;
      6'd5: return a;
      default: ;
    endcase
    if (rins == 0 || rins > 18) return 64'd0;
    w    = 8 << ww;
    n    = 64 / w;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 1);
    res  = 0;
    if (rins == 8 || rins == 9 || rins == 16 || rins == 17) begin
      if (w == 64) return 64'd0;
      for (int p = 0; p < n / 2; p++) begin
        ea = lane_of(a, 2 * p, w, mask);
        oa = lane_of(a, 2 * p + 1, w, mask);
        eb = lane_of(b, 2 * p, w, mask);
        ob = lane_of(b, 2 * p + 1, w, mask);
        case (rins)
          6'd8:    prod = {64'd0, ea} * {64'd0, eb};
          6'd9:    prod = {64'd0, oa} * {64'd0, ob};
          6'd16:   prod = {64'd0, ea} * {64'd0, ea};
          default: prod = {64'd0, oa} * {64'd0, oa};
        endcase
        res |= prod[63:0] << (64 - (p + 1) * 2 * w);
      end
      return res;
    end
    for (int k = 0; k < n; k++) begin
      la = lane_of(a, k, w, mask);
      lb = lane_of(b, k, w, mask);
      s  = int'(lb % 64'(w));
      case (rins)
        6'd6:  r = la + lb;
        6'd7:  r = la - lb;
        6'd10: r = la << s;
        6'd11: r = la >> s;
        6'd12: r = ((la >> (w - 1)) & 64'd1) != 0 ? ((la >> s) | (mask & ~(mask >> s))) : (la >> s);
        6'd13: r = (la << (w / 2)) | (la >> (w / 2));
        6'd14: r = (lb == 0) ? mask : la / lb;
        6'd15: r = (lb == 0) ? la : la % lb;
        default: r = isqrt(la, w);
      endcase
      res |= (r & mask) << (64 - (k + 1) * w);
    end
    return res;
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [5:0] rins,
                       input logic [5:0] opc, input logic [1:0] ww, input logic [63:0] exp);
    @(negedge clk);
    bus.rA_64bit_val = a;
    bus.rB_64bit_val = b;
    bus.R_ins        = rins;
    bus.Op_code      = opc;
    bus.WW           = ww;
    exp_q.push_back(exp);
    tag_q.push_back(rins);
  endtask

  task automatic issue_rand();
    logic [63:0] a, b;
    logic [5:0]  rins, opc;
    logic [1:0]  ww;
    a    = {$urandom, $urandom};
    b    = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: b = 64'd0;
      1: b = b & 64'h0F03_0107_0300_1F0F;
      default: ;
    endcase
    rins = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 19));
    opc  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'b101010;
    ww   = 2'($urandom_range(0, 3));
    issue(a, b, rins, opc, ww, model(a, b, rins, opc, ww));
  endtask

  localparam logic [5:0] OPC = 6'b101010;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.rA_64bit_val = '0;
    bus.rB_64bit_val = '0;
    bus.R_ins        = '0;
    bus.Op_code      = '0;
    bus.WW           = '0;
    repeat (2) @(posedge clk);
    #1 check("reset_state", bus.ALU_out, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Known-answer vectors
    for (int ww = 0; ww < 4; ww++) begin
      issue(64'd15, 64'd14, 6'd1, OPC, 2'(ww), 64'd14);
      issue(64'd15, 64'd14, 6'd2, OPC, 2'(ww), 64'd15);
      issue(64'd15, 64'd14, 6'd3, OPC, 2'(ww), 64'd1);
    end
    issue(64'd0, 64'd5, 6'd4, OPC, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(64'hFFFF_FFFF_0000_0000, 64'h0000_0000_1111_1111, 6'd6, OPC, 2'b10, 64'hFFFF_FFFF_1111_1111);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_1111_1111, 6'd6, OPC, 2'b00, 64'hFFFF_FFFF_1010_1010);
    issue(64'hFF00_0000_FFFF_FFFF, 64'h0002_0000_000F_0001, 6'd8, OPC, 2'b01, 64'h0001_FE00_000E_FFF1);
    issue(64'h20, 64'h20, 6'd9, OPC, 2'b10, 64'h400);
    issue(64'hFFFF_FFFF_0000_0000, 64'd0, 6'd13, OPC, 2'b11, 64'h0000_0000_FFFF_FFFF);
    issue(64'd102, 64'd10, 6'd15, OPC, 2'b11, 64'd2);
    issue(64'd102, 64'd0, 6'd14, OPC, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(64'h0000_0040_0000_0001, 64'd0, 6'd18, OPC, 2'b10, 64'h0000_0008_0000_0001);
    issue(64'h1234_5678_9ABC_DEF0, 64'd3, 6'd16, OPC, 2'b11, 64'd0);
    issue(64'h8000_0000_0000_0000, 64'd4, 6'd12, OPC, 2'b11, 64'hF800_0000_0000_0000);
    issue(64'h0001_0000_0000_0000, 64'd1, 6'd7, OPC, 2'b01, 64'h0001_0000_0000_FFFF);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd1, 6'b101011, 2'b11, 64'd0);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd0, OPC, 2'b11, 64'd0);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd19, OPC, 2'b11, 64'd0);

    for (int i = 0; i < 1500; i++) issue_rand();

    // Asynchronous reset while a nonzero result is held
    issue(64'd15, 64'd14, 6'd2, OPC, 2'b11, 64'd15);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("reset_async", bus.ALU_out, 64'd0);
    @(posedge clk);
    #1 check("reset_hold", bus.ALU_out, 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1 check("reset_release", bus.ALU_out, 64'd0);
    exp_q.push_back(64'd15);
    tag_q.push_back(6'd2);

    for (int i = 0; i < 500; i++) issue_rand();

    repeat (3) @(posedge clk);
    #2 check("drain", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
